skel_thin_engine: RTL and testbench
===================================

SKEL_THIN_ENGINE -- requirements
Module: skel_thin_engine

Interface
REQ-001 Parameter N, default 8: image side length in pixels; the image is N x N, row-major, addr = row*N + col.
REQ-002 Parameter bitSize, default 6: address MSB index; address ports are bitSize+1 bits wide.
REQ-003 Parameter pixelWidth, default 8: pixel word width; a pixel is foreground iff its word is non-zero.
REQ-004 Parameter MAX_PASSES, default 255: upper bound on full thinning passes.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 start  in  1  one-cycle request to begin thinning; sampled only in IDLE.
REQ-008 rd_addr  out  bitSize+1  read address to the image RAM dual read port.
REQ-009 rd_data  in  pixelWidth  RAM dual read data, combinational from rd_addr in the same cycle.
REQ-010 we  out  1  RAM write enable.
REQ-011 wr_addr  out  bitSize+1  RAM primary address.
REQ-012 wr_data  out  pixelWidth  RAM write data, always 0.
REQ-013 busy  out  1  high from the cycle after start is accepted until done.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 pass_count  out  8  number of completed full passes.
REQ-016 limit_hit  out  1  set at done if the run ended on MAX_PASSES rather than convergence.

Function
REQ-017 FSM states: IDLE, SCAN, EVAL, COMMIT, CHECK, FIN; IDLE->SCAN on start; FIN->IDLE after one cycle with done=1.
REQ-018 A full pass is subiteration 1 then subiteration 2; each subiteration is SCAN/EVAL over all interior pixels, followed by COMMIT.
REQ-019 Interior pixels are rows 1..N-2 and cols 1..N-2, visited in row-major order; border pixels are never evaluated and never written.
REQ-020 SCAN: 9 cycles per pixel with rd_addr = P1 (centre), then P2=(r-1,c), P3=(r-1,c+1), P4=(r,c+1), P5=(r+1,c+1), P6=(r+1,c), P7=(r+1,c-1), P8=(r,c-1), P9=(r-1,c-1); each rd_data is latched in the same cycle it is addressed.
REQ-021 EVAL: 1 cycle; B = foreground count of P2..P9 (4 bits); A = number of 0->1 transitions in P2,P3,...,P9,P2.
REQ-022 Delete condition: P1=1, 2<=B<=6, A==1, plus subiteration 1: P2&P4&P6==0 and P4&P6&P8==0; subiteration 2: P2&P4&P8==0 and P2&P6&P8==0.
REQ-023 Deletions are recorded in an internal N*N-bit mark bitmap and are not written to RAM during SCAN (RAM contents stay frozen within a subiteration).
REQ-024 COMMIT: index 0..N*N-1 in order; unmarked index takes 1 cycle with we=0; marked index takes 2 consecutive cycles with we=1, wr_addr=index, wr_data=0 held stable (RAM accepts writes on alternate cycles only).
REQ-025 The bitmap is cleared at the end of COMMIT; a pass-level deletion flag is set if any bit was marked in either subiteration.
REQ-026 CHECK (after subiteration 2 COMMIT): pass_count increments by 1; go to FIN if the deletion flag is 0 or pass_count (new value) == MAX_PASSES, else clear the flag and start subiteration 1.
REQ-027 limit_hit=1 only if FIN was entered with the deletion flag 1; it holds until the next start.
REQ-028 Outside COMMIT: we=0; wr_addr and wr_data=0.
REQ-029 start while busy is ignored; start and done never overlap in a way that restarts without passing through IDLE.
REQ-030 pass_count and limit_hit clear on accepted start and hold their values after done.

Reset
REQ-031 rst_n=0 at a posedge: state=IDLE, we=0, busy=0, done=0, rd_addr=0, wr_addr=0, pass_count=0, limit_hit=0, bitmap and flags cleared; this holds in any state, including mid-COMMIT (a half-finished 2-cycle write is abandoned).

Verification
REQ-032 8x8 all-zero, start -> no we pulses; done with pass_count=1 and limit_hit=0.
REQ-033 2x2 block at addrs 18,19,26,27 -> subiteration 1 COMMIT writes 0 to 18,19,26,27, we high 2 cycles each; pass 2 has no deletions; done with pass_count=2 and the RAM all zero.
REQ-034 1-pixel horizontal line at addrs 25..28 -> no deletions; done with pass_count=1 and the line intact.
REQ-035 Same 2x2 with MAX_PASSES=1 -> done after pass 1 with pass_count=1 and limit_hit=1.
REQ-036 rst_n=0 during the first marked COMMIT cycle -> the next cycle has we=0, busy=0, state IDLE; a subsequent start reruns to a correct result.
REQ-037 start pulsed again while busy -> ignored; pass_count and the final result are identical to a single-start run.

Source files
------------

// File: rtl/skel_thin_engine.sv
// Two-subiteration Zhang-Suen thinning engine over an N x N image held in an external RAM.
// Pixels are read one neighbour per cycle; deletions are buffered in a bitmap and committed after each subiteration.
module skel_thin_engine #(
    parameter int unsigned N          = 8,
    parameter int unsigned bitSize    = 6,
    parameter int unsigned pixelWidth = 8,
    parameter int unsigned MAX_PASSES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [bitSize:0]      rd_addr,
    input  logic [pixelWidth-1:0] rd_data,
    output logic                  we,
    output logic [bitSize:0]      wr_addr,
    output logic [pixelWidth-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            pass_count,
    output logic                  limit_hit
);

    localparam int unsigned AW   = bitSize + 1;
    localparam int unsigned NPIX = N * N;
    localparam int unsigned MW   = $clog2(NPIX);
    localparam int unsigned LAST = N - 2;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SCAN   = 3'd1;
    localparam logic [2:0] EVAL   = 3'd2;
    localparam logic [2:0] COMMIT = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    logic [2:0]      state, state_nxt;
    logic [AW-1:0]   row, col, idx;
    logic [3:0]      k;
    logic [8:0]      p;
    logic            sub, del_flag, ph;
    logic [NPIX-1:0] mark;

    logic [AW-1:0]   row_n_c, col_n_c, cur_c, first_c;
    logic [8:0]      ring_c;
    logic [3:0]      b_cnt_c, a_cnt_c;
    logic            del_c, last_pix_c, step_c, commit_end_c, finish_c;
    logic [7:0]      pc_next_c;

    // Address of neighbour n (0=P1 centre, 1..8=P2..P9 clockwise from north).
    function automatic logic [AW-1:0] nb_addr(input logic [AW-1:0] r, input logic [AW-1:0] c,
                                              input logic [3:0] n);
        int rr;
        int cc;
        rr = int'(r);
        cc = int'(c);
        case (n)
            4'd1:    rr = rr - 1;
            4'd2:    begin rr = rr - 1; cc = cc + 1; end
            4'd3:    cc = cc + 1;
            4'd4:    begin rr = rr + 1; cc = cc + 1; end
            4'd5:    rr = rr + 1;
            4'd6:    begin rr = rr + 1; cc = cc - 1; end
            4'd7:    cc = cc - 1;
            4'd8:    begin rr = rr - 1; cc = cc - 1; end
            default: ;
        endcase
        return AW'(rr * int'(N) + cc);
    endfunction

    // Neighbourhood evaluation and traversal helpers.
    always_comb begin
        b_cnt_c = '0;
        a_cnt_c = '0;
        ring_c  = {p[1], p[8:1]};
        for (int i = 0; i < 8; i++) begin
            b_cnt_c = b_cnt_c + 4'(ring_c[i]);
            a_cnt_c = a_cnt_c + 4'(!ring_c[i] && ring_c[i+1]);
        end
        del_c = p[0] && (b_cnt_c >= 4'd2) && (b_cnt_c <= 4'd6) && (a_cnt_c == 4'd1) &&
                (sub ? (!(p[1] & p[3] & p[7]) && !(p[1] & p[5] & p[7]))
                     : (!(p[1] & p[3] & p[5]) && !(p[3] & p[5] & p[7])));

        if (col == AW'(LAST)) begin
            col_n_c = AW'(1);
            row_n_c = row + AW'(1);
        end else begin
            col_n_c = col + AW'(1);
            row_n_c = row;
        end
        cur_c        = nb_addr(row, col, 4'd0);
        first_c      = nb_addr(AW'(1), AW'(1), 4'd0);
        last_pix_c   = (row == AW'(LAST)) && (col == AW'(LAST));
        step_c       = !(mark[MW'(idx)] && !ph);
        commit_end_c = step_c && (idx == AW'(NPIX - 1));
        pc_next_c    = pass_count + 8'd1;
        finish_c     = !del_flag || (pc_next_c == 8'(MAX_PASSES));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (k == 4'd8) state_nxt = EVAL;
            EVAL:    state_nxt = last_pix_c ? COMMIT : SCAN;
            COMMIT:  if (commit_end_c) state_nxt = sub ? CHECK : SCAN;
            CHECK:   state_nxt = finish_c ? FIN : SCAN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign wr_data = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr    <= '0;
            wr_addr    <= '0;
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_count <= '0;
            limit_hit  <= 1'b0;
            row        <= '0;
            col        <= '0;
            idx        <= '0;
            k          <= '0;
            p          <= '0;
            sub        <= 1'b0;
            del_flag   <= 1'b0;
            ph         <= 1'b0;
            mark       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy       <= 1'b1;
                    pass_count <= '0;
                    limit_hit  <= 1'b0;
                    del_flag   <= 1'b0;
                    sub        <= 1'b0;
                    mark       <= '0;
                    row        <= AW'(1);
                    col        <= AW'(1);
                    k          <= '0;
                    rd_addr    <= first_c;
                end
                SCAN: begin
                    p[k] <= |rd_data;
                    if (k == 4'd8) begin
                        k <= '0;
                    end else begin
                        k       <= k + 4'd1;
                        rd_addr <= nb_addr(row, col, k + 4'd1);
                    end
                end
                EVAL: begin
                    if (del_c) begin
                        mark[MW'(cur_c)] <= 1'b1;
                        del_flag         <= 1'b1;
                    end
                    if (last_pix_c) begin
                        idx     <= '0;
                        ph      <= 1'b0;
                        we      <= 1'b0;
                        wr_addr <= '0;
                    end else begin
                        row     <= row_n_c;
                        col     <= col_n_c;
                        rd_addr <= nb_addr(row_n_c, col_n_c, 4'd0);
                    end
                end
                // A marked index holds we/wr_addr for two cycles before moving on.
                COMMIT: begin
                    if (!step_c) begin
                        ph <= 1'b1;
                    end else if (commit_end_c) begin
                        mark    <= '0;
                        we      <= 1'b0;
                        wr_addr <= '0;
                        ph      <= 1'b0;
                        if (!sub) begin
                            sub     <= 1'b1;
                            row     <= AW'(1);
                            col     <= AW'(1);
                            k       <= '0;
                            rd_addr <= first_c;
                        end
                    end else begin
                        idx     <= idx + AW'(1);
                        ph      <= 1'b0;
                        we      <= mark[MW'(idx + AW'(1))];
                        wr_addr <= mark[MW'(idx + AW'(1))] ? idx + AW'(1) : '0;
                    end
                end
                CHECK: begin
                    pass_count <= pc_next_c;
                    if (finish_c) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        limit_hit <= del_flag;
                    end else begin
                        del_flag <= 1'b0;
                        sub      <= 1'b0;
                        row      <= AW'(1);
                        col      <= AW'(1);
                        k        <= '0;
                        rd_addr  <= first_c;
                    end
                end
                FIN: done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skel_thin_engine.sv
// Scoreboard bench for skel_thin_engine: stimulus queues expected writes/completions, monitors pop and compare.
module tb_skel_thin_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start0, start1;
    logic [6:0] rd_addr0, wr_addr0, rd_addr1, wr_addr1;
    logic [7:0] rd_data0, wr_data0, rd_data1, wr_data1;
    logic       we0, busy0, done0, limit_hit0;
    logic       we1, busy1, done1, limit_hit1;
    logic [7:0] pass_count0, pass_count1;

    logic [7:0]  ram0 [64];
    logic [7:0]  ram1 [64];
    logic [63:0] img0, img1;
    logic        ld0, ld1;

    typedef struct {int pc; int lh;} done_t;
    int    exp_wr[$];
    done_t exp_done0[$];
    done_t exp_done1[$];

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] BLOCK = 64'h0000_0000_0C0C_0000;
    localparam logic [63:0] LINE  = 64'h0000_0000_1E00_0000;

    skel_thin_engine dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .we(we0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0), .done(done0),
        .pass_count(pass_count0), .limit_hit(limit_hit0)
    );

    skel_thin_engine #(.MAX_PASSES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .we(we1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1), .done(done1),
        .pass_count(pass_count1), .limit_hit(limit_hit1)
    );

    // RAM models: combinational read, write on posedge; image load via ld request.
    assign rd_data0 = ram0[rd_addr0[5:0]];
    assign rd_data1 = ram1[rd_addr1[5:0]];

    always @(posedge clk) begin
        if (ld0) for (int i = 0; i < 64; i++) ram0[i] <= img0[i] ? 8'(i + 1) : 8'h00;
        else if (we0) ram0[wr_addr0[5:0]] <= wr_data0;
    end

    always @(posedge clk) begin
        if (ld1) for (int i = 0; i < 64; i++) ram1[i] <= img1[i] ? 8'(i + 1) : 8'h00;
        else if (we1) ram1[wr_addr1[5:0]] <= wr_data1;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor for dut0: write pairs and completion pulses.
    logic       wph;
    logic [6:0] last_wa;
    always @(negedge clk) begin
        done_t d;
        if (!rst_n) begin
            wph = 1'b0;
        end else begin
            if (we0) begin
                check("wr_data", 64'(wr_data0), 64'd0);
                if (!wph) begin
                    if (exp_wr.size() == 0) check("unexpected_write", 64'(wr_addr0), 64'hFFFF);
                    else check("wr_addr", 64'(wr_addr0), 64'(exp_wr.pop_front()));
                    last_wa = wr_addr0;
                    wph     = 1'b1;
                end else begin
                    check("wr_hold", 64'(wr_addr0), 64'(last_wa));
                    wph = 1'b0;
                end
            end else begin
                if (wph) check("we_width", 64'(we0), 64'd1);
                wph = 1'b0;
                check("idle_wr_addr", 64'(wr_addr0), 64'd0);
            end
            if (done0) begin
                if (exp_done0.size() == 0) begin
                    check("unexpected_done", 64'(pass_count0), 64'hFFFF);
                end else begin
                    d = exp_done0.pop_front();
                    check("pass_count", 64'(pass_count0), 64'(d.pc));
                    check("limit_hit", 64'(limit_hit0), 64'(d.lh));
                    check("busy_at_done", 64'(busy0), 64'd0);
                end
            end
        end
    end

    // Monitor for dut1 (MAX_PASSES=1) completions.
    always @(negedge clk) begin
        done_t d;
        if (rst_n && done1) begin
            if (exp_done1.size() == 0) begin
                check("unexpected_done1", 64'(pass_count1), 64'hFFFF);
            end else begin
                d = exp_done1.pop_front();
                check("pass_count1", 64'(pass_count1), 64'(d.pc));
                check("limit_hit1", 64'(limit_hit1), 64'(d.lh));
            end
        end
    end

    task automatic load(input int which, input logic [63:0] m);
        if (which == 0) begin img0 = m; ld0 = 1'b1; end
        else            begin img1 = m; ld1 = 1'b1; end
        @(posedge clk);
        #1;
        ld0 = 1'b0;
        ld1 = 1'b0;
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic run_start(input int which);
        pulse_start(which);
        if (which == 0) begin
            check("busy_after_start", 64'(busy0), 64'd1);
            check("pc_cleared", 64'(pass_count0), 64'd0);
            check("lh_cleared", 64'(limit_hit0), 64'd0);
        end else begin
            check("busy1_after_start", 64'(busy1), 64'd1);
        end
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && done0) || (which == 1 && done1)) return;
        end
        if (which == 0) check("done_timeout", 64'(done0), 64'd1);
        else            check("done1_timeout", 64'(done1), 64'd1);
    endtask

    function automatic logic [63:0] ram_mask(input int which);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = (which == 0) ? (ram0[i] != 8'h00) : (ram1[i] != 8'h00);
        return m;
    endfunction

    task automatic push_block_writes();
        exp_wr.push_back(18);
        exp_wr.push_back(19);
        exp_wr.push_back(26);
        exp_wr.push_back(27);
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        ld0    = 1'b0;
        ld1    = 1'b0;
        img0   = '0;
        img1   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 64'(we0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_rd_addr", 64'(rd_addr0), 64'd0);
        check("rst_wr_addr", 64'(wr_addr0), 64'd0);
        check("rst_pass_count", 64'(pass_count0), 64'd0);
        check("rst_limit_hit", 64'(limit_hit0), 64'd0);
        rst_n = 1'b1;

        // All-zero image: nothing to delete, one pass.
        load(0, 64'd0);
        exp_done0.push_back('{pc: 1, lh: 0});
        run_start(0);
        wait_done(0);
        check("zero_ram", ram_mask(0), 64'd0);

        // 2x2 block: fully removed in subiteration 1, second pass converges.
        load(0, BLOCK);
        push_block_writes();
        exp_done0.push_back('{pc: 2, lh: 0});
        run_start(0);
        wait_done(0);
        check("block_ram", ram_mask(0), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("pc_hold", 64'(pass_count0), 64'd2);

        // One-pixel line: endpoints have B=1, interior A=2, so nothing is removed.
        load(0, LINE);
        exp_done0.push_back('{pc: 1, lh: 0});
        run_start(0);
        wait_done(0);
        check("line_ram", ram_mask(0), LINE);

        // Reset during the first marked commit cycle abandons the run.
        load(0, BLOCK);
        push_block_writes();
        pulse_start(0);
        begin
            int n;
            n = 0;
            while (!we0 && n < 5000) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("we_seen", 64'(we0), 64'd1);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_we", 64'(we0), 64'd0);
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_pc", 64'(pass_count0), 64'd0);
        exp_wr.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Rerun after abort, with a stray start while busy that must be ignored.
        load(0, BLOCK);
        push_block_writes();
        exp_done0.push_back('{pc: 2, lh: 0});
        run_start(0);
        repeat (20) @(posedge clk);
        pulse_start(0);
        wait_done(0);
        check("rerun_ram", ram_mask(0), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rerun_busy", 64'(busy0), 64'd0);

        // MAX_PASSES=1: stops after the first pass with deletions pending.
        load(1, BLOCK);
        exp_done1.push_back('{pc: 1, lh: 1});
        run_start(1);
        wait_done(1);
        check("limit_ram", ram_mask(1), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("limit_hold", 64'(limit_hit1), 64'd1);

        repeat (3) @(posedge clk);
        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("done0_queue_empty", 64'(exp_done0.size()), 64'd0);
        check("done1_queue_empty", 64'(exp_done1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
